step_dir_decoder: RTL and testbench
===================================

Name: step_dir_decoder

Overview:
Receive side of the step/direction interface that our stepper controllers drive. The block samples an external STEP/DIR pair and keeps a signed axis position. It also reports a step count, the measured step period, and motion and fault status. The processor reads these through the register file to get closed-loop position feedback for the plotter axes. One instance is used per axis.

Parameters:
IDLE_CYCLES, 32'd50000, number of step-free cycles after which the axis is reported stopped
MIN_PERIOD, 32'd100, minimum legal spacing of step events in clock cycles; closer spacing flags overrun
POS_MIN, -32'sd100000, lower soft limit of position (signed)
POS_MAX, 32'sd100000, upper soft limit of position (signed)
DIR_POSITIVE, 1'b1, level of dir_in that means +1 step

Ports:
clock  input  1  system clock; the only clock. All state changes on the rising edge.
reset  input  1  asynchronous, active-high reset
step_in  input  1  asynchronous STEP line; a rising edge is one step
dir_in  input  1  asynchronous DIR line
clear  input  1  synchronous clear of the position, count and sticky flags
position  output  32  signed axis position
step_count  output  32  unsigned total accepted step events
last_period  output  32  cycles between the two most recent step events
moving  output  1  high while steps arrive within IDLE_CYCLES
limit_hit  output  1  sticky flag: a step was blocked at a soft limit
overrun  output  1  sticky flag: a step arrived sooner than MIN_PERIOD after the previous one

Behaviour:
- Reset (async, while reset=1): all registers are 0, including the synchronisers and the period counter. Outputs: position=0, step_count=0, last_period=0, moving=0, limit_hit=0, overrun=0. FSM is in IDLE.
- Synchronisation: step_in and dir_in each pass through a 2-FF synchroniser (s1, s2). A step_prev register holds the previous s2.
- Step event: s2 & ~step_prev. Direction is taken from dir s2 in the same cycle.
- Latency: step_in is first sampled high on edge k. The outputs show the step after edge k+2.
- Position update on a step event: add +1 if dir equals DIR_POSITIVE, else -1.
  - If the step would move position past POS_MAX or below POS_MIN, position holds and limit_hit is set to 1.
  - step_count still increments on a blocked step.
  - Arithmetic is 32-bit signed. POS_MIN < POS_MAX is required.
- step_count: increments by 1 per step event and wraps from 32'hFFFFFFFF to 0.
- Period counter (internal, 32-bit):
  - Increments every cycle and saturates at 32'hFFFFFFFF.
  - On a step event: last_period takes the counter value and the counter loads 1.
  - The first step after reset or clear leaves last_period = 0; the first valid period comes from the second step.
- overrun: set when a step event occurs while the counter < MIN_PERIOD, excluding the first step after reset or clear. The step is still applied.
- FSM, two states:
  - IDLE (moving=0) goes to MOVING on a step event.
  - MOVING (moving=1) goes to IDLE when the counter reaches IDLE_CYCLES with no step in that cycle.
  - A step on the same cycle keeps MOVING.
  - moving is a registered output of the state.
- clear=1, synchronous:
  - Zeroes position, step_count, last_period, limit_hit, overrun and the counter.
  - Re-arms the first-step qualifier. FSM goes to IDLE.
  - A step event in the same cycle is discarded: clear wins.
  - Synchronisers are not cleared.
- Reset mid-motion: async reset takes effect immediately. Any pulse already in the synchronisers is lost.
- A held-high step_in counts once. Pulses narrower than one clock may be missed, which is acceptable because the driver guarantees at least 2 cycles high and 2 cycles low.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE, ST_MOVING) and the default constants for IDLE_CYCLES and MIN_PERIOD, so that the driving stepper controller uses the same values.
- One natural sub-module: sync_edge_detect (2-FF sync plus a rising-edge pulse). It is instantiated for step_in; dir_in uses only its synchronised output.

Test Plan:
1. Reset, then 5 step pulses with dir=1 spaced 1000 cycles apart.
   Expect: position=5, step_count=5, last_period=1000, moving=1, overrun=0. After 50000 idle cycles, moving=0.
2. From position 5, 8 steps with dir=0.
   Expect: position=-3 (32'hFFFFFFFD), step_count=13.
3. Set POS_MAX=3, then 5 steps with dir=1.
   Expect: position=3, step_count=5, limit_hit=1. A later dir=0 step gives position=2 and limit_hit stays 1.
4. Two steps 50 cycles apart.
   Expect: overrun=1, last_period=50, step_count=2. A single first step alone leaves overrun=0.
5. Assert clear in the same cycle as a step event.
   Expect: all outputs 0 next cycle, and the step is not counted.
6. Assert async reset midway through a 10-step burst.
   Expect: outputs are 0 immediately, with no clock edge required. Steps after release count from 0, with the first visible 3 edges after sampling.

Source files
------------

// File: rtl/step_dir_decoder_pkg.sv
// Shared definitions for the step/direction receive path: FSM encoding and
// default timing constants also used by the driving stepper controller.
package step_dir_decoder_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_MOVING = 1'b1
   } state_t;

   localparam logic [31:0] IDLE_CYCLES_DEF = 32'd50000;
   localparam logic [31:0] MIN_PERIOD_DEF  = 32'd100;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/step_dir_decoder_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input with a one-cycle rising-edge
// pulse derived from the synchronised level.
module sync_edge_detect (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_s1   <= i_async;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign o_sync = r_s2;
   assign o_rise = r_s2 & ~r_prev;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/direction receiver: tracks signed axis position with soft limits, step
// count, step period, motion state and sticky overrun/limit flags.
module step_dir_decoder
   import step_dir_decoder_pkg::*;
#(
   parameter logic [31:0]        IDLE_CYCLES  = IDLE_CYCLES_DEF,
   parameter logic [31:0]        MIN_PERIOD   = MIN_PERIOD_DEF,
   parameter logic signed [31:0] POS_MIN      = -32'sd100000,
   parameter logic signed [31:0] POS_MAX      = 32'sd100000,
   parameter logic               DIR_POSITIVE = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               step_in,
   input  logic               dir_in,
   input  logic               clear,
   output logic signed [31:0] position,
   output logic [31:0]        step_count,
   output logic [31:0]        last_period,
   output logic               moving,
   output logic               limit_hit,
   output logic               overrun
);

   localparam logic signed [32:0] W_POS_MIN = 33'(POS_MIN);
   localparam logic signed [32:0] W_POS_MAX = 33'(POS_MAX);

   logic w_step_evt;
   logic w_step_sync;
   logic w_dir_s;
   logic w_unused_dir_rise;

   sync_edge_detect u_step_sync (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_async (step_in),
      .o_sync  (w_step_sync),
      .o_rise  (w_step_evt)
   );

   sync_edge_detect u_dir_sync (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_async (dir_in),
      .o_sync  (w_dir_s),
      .o_rise  (w_unused_dir_rise)
   );

   state_t             r_state;
   state_t             w_state_next;
   logic signed [31:0] r_position;
   logic [31:0]        r_count;
   logic [31:0]        r_last_period;
   logic [31:0]        r_period_cnt;
   logic               r_limit_hit;
   logic               r_overrun;
   logic               r_seen_step;

   logic signed [32:0] w_pos_try;
   logic               w_blocked;

   // Widened to 33 bits so the limit test cannot be fooled by wrap-around.
   always_comb begin
      w_pos_try = {r_position[31], r_position};
      if (w_dir_s == DIR_POSITIVE) begin
         w_pos_try = w_pos_try + 33'sd1;
      end else begin
         w_pos_try = w_pos_try - 33'sd1;
      end
      w_blocked = (w_pos_try > W_POS_MAX) || (w_pos_try < W_POS_MIN);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_step_evt) w_state_next = ST_MOVING;
         end
         ST_MOVING: begin
            if (!w_step_evt && (r_period_cnt >= IDLE_CYCLES)) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
      if (clear) w_state_next = ST_IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_position    <= '0;
         r_count       <= '0;
         r_last_period <= '0;
         r_period_cnt  <= '0;
         r_limit_hit   <= 1'b0;
         r_overrun     <= 1'b0;
         r_seen_step   <= 1'b0;
      end else if (clear) begin
         r_position    <= '0;
         r_count       <= '0;
         r_last_period <= '0;
         r_period_cnt  <= '0;
         r_limit_hit   <= 1'b0;
         r_overrun     <= 1'b0;
         r_seen_step   <= 1'b0;
      end else if (w_step_evt) begin
         r_count      <= r_count + 32'd1;
         r_period_cnt <= 32'd1;
         r_seen_step  <= 1'b1;
         // The first step has no predecessor, so it yields no period and no overrun.
         if (r_seen_step) begin
            r_last_period <= r_period_cnt;
            if (r_period_cnt < MIN_PERIOD) r_overrun <= 1'b1;
         end
         if (w_blocked) begin
            r_limit_hit <= 1'b1;
         end else begin
            r_position <= w_pos_try[31:0];
         end
      end else begin
         r_period_cnt <= sat_inc(r_period_cnt);
      end
   end

   assign position    = r_position;
   assign step_count  = r_count;
   assign last_period = r_last_period;
   assign moving      = (r_state == ST_MOVING);
   assign limit_hit   = r_limit_hit;
   assign overrun     = r_overrun;

   // Synchronised step level is only consumed through the edge pulse.
   logic w_unused_step_sync;
   assign w_unused_step_sync = w_step_sync;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed self-checking bench; dut1 uses default limits, dut2 has POS_MAX=3
// and shares every input with dut1.
module tb_step_dir_decoder;

   logic               clock;
   logic               reset;
   logic               step_in;
   logic               dir_in;
   logic               clear;
   logic signed [31:0] pos1, pos2;
   logic [31:0]        cnt1, cnt2;
   logic [31:0]        per1, per2;
   logic               mov1, mov2;
   logic               lim1, lim2;
   logic               ovr1, ovr2;

   int checks = 0;
   int errors = 0;

   step_dir_decoder dut1 (
      .clock(clock), .reset(reset), .step_in(step_in), .dir_in(dir_in), .clear(clear),
      .position(pos1), .step_count(cnt1), .last_period(per1), .moving(mov1),
      .limit_hit(lim1), .overrun(ovr1)
   );

   step_dir_decoder #(.POS_MAX(32'sd3)) dut2 (
      .clock(clock), .reset(reset), .step_in(step_in), .dir_in(dir_in), .clear(clear),
      .position(pos2), .step_count(cnt2), .last_period(per2), .moving(mov2),
      .limit_hit(lim2), .overrun(ovr2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_step(input logic d, input int unsigned spacing);
      dir_in  = d;
      step_in = 1'b1;
      tick(4);
      step_in = 1'b0;
      tick(spacing - 4);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      reset = 1'b1; step_in = 1'b0; dir_in = 1'b0; clear = 1'b0;
      tick(3);
      checks++; if (pos1 !== 32'sd0) begin errors++; $display("FAIL rst_position got %0d exp 0", pos1); end
      checks++; if (cnt1 !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", cnt1); end
      checks++; if (per1 !== 32'd0) begin errors++; $display("FAIL rst_period got %0d exp 0", per1); end
      checks++; if ({mov1, lim1, ovr1} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {mov1, lim1, ovr1}); end
      reset = 1'b0;
      tick(2);
      checks++; if ({cnt1, pos2} !== 64'd0) begin errors++; $display("FAIL rst_release got cnt=%0d pos2=%0d exp 0", cnt1, pos2); end
   endtask

   task automatic test_limit();
      do_reset();
      for (int i = 0; i < 5; i++) do_step(1'b1, 200);
      checks++; if (pos2 !== 32'sd3) begin errors++; $display("FAIL lim_position got %0d exp 3", pos2); end
      checks++; if (cnt2 !== 32'd5) begin errors++; $display("FAIL lim_count got %0d exp 5", cnt2); end
      checks++; if (lim2 !== 1'b1) begin errors++; $display("FAIL lim_flag got %b exp 1", lim2); end
      checks++; if ({pos1, lim1} !== {32'sd5, 1'b0}) begin errors++; $display("FAIL lim_unlimited got pos=%0d lim=%b exp 5,0", pos1, lim1); end
      do_step(1'b0, 200);
      checks++; if (pos2 !== 32'sd2) begin errors++; $display("FAIL lim_back_position got %0d exp 2", pos2); end
      checks++; if (lim2 !== 1'b1) begin errors++; $display("FAIL lim_sticky got %b exp 1", lim2); end
      checks++; if (pos1 !== 32'sd4) begin errors++; $display("FAIL lim_dut1_back got %0d exp 4", pos1); end
   endtask

   task automatic test_forward();
      do_reset();
      for (int i = 0; i < 5; i++) do_step(1'b1, 1000);
      checks++; if (pos1 !== 32'sd5) begin errors++; $display("FAIL fwd_position got %0d exp 5", pos1); end
      checks++; if (cnt1 !== 32'd5) begin errors++; $display("FAIL fwd_count got %0d exp 5", cnt1); end
      checks++; if (per1 !== 32'd1000) begin errors++; $display("FAIL fwd_period got %0d exp 1000", per1); end
      checks++; if (mov1 !== 1'b1) begin errors++; $display("FAIL fwd_moving got %b exp 1", mov1); end
      checks++; if (ovr1 !== 1'b0) begin errors++; $display("FAIL fwd_overrun got %b exp 0", ovr1); end
      tick(48900);
      checks++; if (mov1 !== 1'b1) begin errors++; $display("FAIL fwd_still_moving got %b exp 1", mov1); end
      tick(200);
      checks++; if (mov1 !== 1'b0) begin errors++; $display("FAIL fwd_stopped got %b exp 0", mov1); end
   endtask

   task automatic test_reverse();
      for (int i = 0; i < 8; i++) do_step(1'b0, 200);
      checks++; if (pos1 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL rev_position got %0d exp -3", pos1); end
      checks++; if (cnt1 !== 32'd13) begin errors++; $display("FAIL rev_count got %0d exp 13", cnt1); end
      checks++; if (per1 !== 32'd200) begin errors++; $display("FAIL rev_period got %0d exp 200", per1); end
   endtask

   task automatic test_overrun();
      clear = 1'b1; tick(1); clear = 1'b0; tick(1);
      do_step(1'b1, 50);
      checks++; if ({ovr1, per1, cnt1} !== {1'b0, 32'd0, 32'd1}) begin errors++; $display("FAIL ovr_first got ovr=%b per=%0d cnt=%0d exp 0,0,1", ovr1, per1, cnt1); end
      do_step(1'b1, 50);
      checks++; if (ovr1 !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", ovr1); end
      checks++; if ({per1, cnt1} !== {32'd50, 32'd2}) begin errors++; $display("FAIL ovr_period_count got per=%0d cnt=%0d exp 50,2", per1, cnt1); end
      clear = 1'b1; tick(1); clear = 1'b0; tick(1);
      do_step(1'b1, 100);
      do_step(1'b1, 99);
      checks++; if ({ovr1, per1} !== {1'b0, 32'd100}) begin errors++; $display("FAIL ovr_at_min got ovr=%b per=%0d exp 0,100", ovr1, per1); end
      do_step(1'b1, 10);
      checks++; if ({ovr1, per1} !== {1'b1, 32'd99}) begin errors++; $display("FAIL ovr_below_min got ovr=%b per=%0d exp 1,99", ovr1, per1); end
   endtask

   task automatic test_clear_collision();
      do_step(1'b1, 200);
      step_in = 1'b1;
      tick(2);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      checks++; if ({pos1, cnt1, per1} !== 96'd0) begin errors++; $display("FAIL clr_values got pos=%0d cnt=%0d per=%0d exp 0", pos1, cnt1, per1); end
      checks++; if ({mov1, lim1, ovr1, lim2} !== 4'b0000) begin errors++; $display("FAIL clr_flags got %b exp 0000", {mov1, lim1, ovr1, lim2}); end
      tick(3);
      step_in = 1'b0;
      tick(20);
      checks++; if (cnt1 !== 32'd0) begin errors++; $display("FAIL clr_discard got %0d exp 0", cnt1); end
      do_step(1'b0, 30);
      checks++; if ({pos1, cnt1} !== {32'hFFFF_FFFF, 32'd1}) begin errors++; $display("FAIL clr_rearm got pos=%0d cnt=%0d exp -1,1", pos1, cnt1); end
      checks++; if ({ovr1, per1} !== {1'b0, 32'd0}) begin errors++; $display("FAIL clr_first_step got ovr=%b per=%0d exp 0,0", ovr1, per1); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) do_step(1'b1, 200);
      dir_in  = 1'b1;
      step_in = 1'b1;
      tick(1);
      reset = 1'b1;
      #1;
      checks++; if ({pos1, cnt1, per1} !== 96'd0) begin errors++; $display("FAIL arst_values got pos=%0d cnt=%0d per=%0d exp 0", pos1, cnt1, per1); end
      checks++; if ({mov1, lim1, ovr1} !== 3'b000) begin errors++; $display("FAIL arst_flags got %b exp 000", {mov1, lim1, ovr1}); end
      step_in = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(5);
      checks++; if (cnt1 !== 32'd0) begin errors++; $display("FAIL arst_lost_pulse got %0d exp 0", cnt1); end
      step_in = 1'b1;
      tick(2);
      checks++; if (cnt1 !== 32'd0) begin errors++; $display("FAIL arst_latency_early got %0d exp 0", cnt1); end
      tick(1);
      checks++; if ({pos1, cnt1} !== {32'sd1, 32'd1}) begin errors++; $display("FAIL arst_latency got pos=%0d cnt=%0d exp 1,1", pos1, cnt1); end
      step_in = 1'b0;
      tick(197);
      for (int i = 0; i < 3; i++) do_step(1'b1, 200);
      checks++; if ({pos1, cnt1, per1} !== {32'sd4, 32'd4, 32'd200}) begin errors++; $display("FAIL arst_resume got pos=%0d cnt=%0d per=%0d exp 4,4,200", pos1, cnt1, per1); end
      checks++; if (mov1 !== 1'b1) begin errors++; $display("FAIL arst_moving got %b exp 1", mov1); end
   endtask

   initial begin
      test_reset();
      test_limit();
      test_forward();
      test_reverse();
      test_overrun();
      test_clear_collision();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
